n64_response_decoder: RTL and testbench

N64_RESPONSE_DECODER -- requirements
Module: n64_response_decoder

---
 rtl/n64_pkg.sv | 24 ++
 rtl/n64_edge_sync.sv | 27 ++
 rtl/n64_response_decoder.sv | 151 +++++++++++++++
 tb/tb_n64_response_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared N64 controller-bus definitions: receive-FSM states, bus timing and poll command constants.
package n64_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOW,
        ST_HIGH,
        ST_STOP
    } n64_rx_state_t;

    // One quarter-bit is 1 us of PCLK; a full bit cell is four quarters.
    localparam int N64_QUARTER_CYCLES   = 96;
    localparam int N64_TIMEOUT_QUARTERS = 16;
    localparam int N64_TIMEOUT_CYCLES   = N64_QUARTER_CYCLES * N64_TIMEOUT_QUARTERS;
    localparam int N64_FRAME_BITS       = 32;
    localparam int N64_CMD_BITS         = 8;
    localparam logic [7:0] N64_CMD_POLL = 8'h01;

    function automatic logic [15:0] n64_cyc16(input int n);
        return 16'(n);
    endfunction

endpackage

// File: rtl/n64_edge_sync.sv
// Two-flop synchroniser for the raw N64 line, with edge detect looking one stage ahead.
module n64_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);
    logic r_s1, r_s2;

    // Idle line is high, so reset to 1 to avoid a false falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_level = r_s2;
    assign o_fall  = r_s2 & ~r_s1;
    assign o_rise  = ~r_s2 & r_s1;

endmodule

// File: rtl/n64_response_decoder.sv
// Decodes the 32-bit controller response on the N64 line into a valid/ready word, flagging bad frames.
module n64_response_decoder
    import n64_pkg::*;
#(
    parameter int QUARTER_CYCLES = N64_QUARTER_CYCLES,
    parameter int TIMEOUT_CYCLES = N64_TIMEOUT_CYCLES
) (
    input  logic        i_pclk,
    input  logic        i_preset,
    input  logic        i_arm,
    input  logic        i_n64_rx,
    output logic [31:0] o_data,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic        o_frame_err,
    output logic        o_overrun,
    output logic        o_busy
);
    localparam logic [15:0] L_GLITCH = n64_cyc16(QUARTER_CYCLES / 4);
    localparam logic [15:0] L_ONE    = n64_cyc16(2 * QUARTER_CYCLES);
    localparam logic [15:0] L_STUCK  = n64_cyc16(4 * QUARTER_CYCLES);
    localparam logic [15:0] L_TMO    = n64_cyc16(TIMEOUT_CYCLES);

    logic          w_level, w_fall, w_rise;
    n64_rx_state_t r_state, w_state_nxt;
    logic [15:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [5:0]    r_bits, w_bits_nxt;
    logic [31:0]   r_shift, w_shift_nxt;
    logic          w_done, w_err;
    logic          r_done, r_err;
    logic [31:0]   r_data;
    logic          r_valid, r_ovr;

    n64_edge_sync u_sync (
        .i_clk   (i_pclk),
        .i_rst   (i_preset),
        .i_d     (i_n64_rx),
        .o_level (w_level),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_HUNT;
            ST_HUNT: if (w_fall) begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
                w_bits_nxt  = '0;
            end
            ST_LOW: begin
                if (w_rise) begin
                    if (r_cnt < L_GLITCH) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_shift_nxt = {r_shift[30:0], (r_cnt < L_ONE)};
                        w_bits_nxt  = r_bits + 6'd1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HIGH;
                    end
                end else if (r_cnt >= L_STUCK) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_bits < 6'(N64_FRAME_BITS)) ? ST_LOW : ST_STOP;
                end else if (r_cnt >= L_TMO) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_HUNT;
                end else if (w_level) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_STOP: begin
                if (w_rise) begin
                    w_done      = (r_cnt >= L_GLITCH) && (r_cnt < L_STUCK);
                    w_err       = !w_done;
                    w_state_nxt = ST_HUNT;
                end else if (r_cnt >= L_STUCK) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Losing ARM silently abandons whatever frame was in flight.
        if (!i_arm) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
            w_err       = 1'b0;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    // A completed frame only replaces DATA if the old word is gone or leaving this cycle.
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (r_done && (!r_valid || i_data_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
        end else begin
            if (r_done)
                r_ovr <= 1'b1;
            if (r_valid && i_data_ready)
                r_valid <= 1'b0;
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_frame_err  = r_err;
    assign o_overrun    = r_ovr;
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_HUNT);

endmodule

// File: tb/tb_n64_response_decoder.sv
// Randomised and directed bench for n64_response_decoder against a frame-level model.
module tb_n64_response_decoder;
    localparam int Q   = 48;
    localparam int TMO = 16 * Q;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        arm = 1'b0;
    logic        rx = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] data;
    logic        valid, err, ovr, busy;

    int n_chk = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int err_base;

    logic [31:0] mdata;
    logic        mvalid, movr;
    logic [31:0] w;

    n64_response_decoder #(.QUARTER_CYCLES(Q), .TIMEOUT_CYCLES(TMO)) dut (
        .i_pclk       (clk),
        .i_preset     (preset),
        .i_arm        (arm),
        .i_n64_rx     (rx),
        .o_data       (data),
        .o_data_valid (valid),
        .i_data_ready (ready),
        .o_frame_err  (err),
        .o_overrun    (ovr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Counts cycles with FRAME_ERR high; a single one-cycle pulse adds exactly 1.
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // A '1' is a short low then long high; a '0' the reverse. Jitter stays clear of the thresholds.
    task automatic send_bits(input logic [31:0] word, input int nbits, input bit jit);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            int lo, hi;
            b = word[31-i];
            if (!jit) begin
                lo = b ? Q : 3 * Q;
                hi = b ? 3 * Q : Q;
            end else begin
                lo = b ? $urandom_range(2 * Q - 4, Q / 4 + 4) : $urandom_range(4 * Q - 8, 2 * Q + 4);
                hi = $urandom_range(3 * Q, Q / 2);
            end
            hold(1'b0, lo);
            hold(1'b1, hi);
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input bit jit);
        send_bits(word, 32, jit);
        hold(1'b0, Q);
        hold(1'b1, 3 * Q);
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_data", data, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_ovr", {31'h0, ovr}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        preset = 1'b0;
        arm = 1'b1;
        hold(1'b1, 10);
        chk("hunt_busy", {31'h0, busy}, 32'h0);

        // Single-bit frame, exact stop-edge latency.
        send_bits(32'h8000_0000, 32, 1'b0);
        hold(1'b0, Q);
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_pre", {31'h0, valid}, 32'h0);
        @(negedge clk);
        chk("lat_valid", {31'h0, valid}, 32'h1);
        chk("lat_data", data, 32'h8000_0000);
        hold(1'b1, 2 * Q);
        consume();
        chk("consume", {31'h0, valid}, 32'h0);

        // Ready held high: exactly one cycle of valid.
        ready = 1'b1;
        send_bits(32'hA5A5_0F0F, 32, 1'b0);
        hold(1'b0, Q);
        hold(1'b1, 3);
        chk("acc_valid", {31'h0, valid}, 32'h1);
        chk("acc_data", data, 32'hA5A5_0F0F);
        @(negedge clk);
        chk("acc_drop", {31'h0, valid}, 32'h0);
        ready = 1'b0;
        hold(1'b1, Q);

        // Second frame while the first is unconsumed is dropped.
        send_frame(32'h1234_5678, 1'b0);
        chk("ovr_first", data, 32'h1234_5678);
        chk("ovr_clear", {31'h0, ovr}, 32'h0);
        send_frame(32'hFFFF_FFFF, 1'b0);
        chk("ovr_keep", data, 32'h1234_5678);
        chk("ovr_valid", {31'h0, valid}, 32'h1);
        chk("ovr_set", {31'h0, ovr}, 32'h1);

        // High-time timeout after ten bits, with an old word still pending.
        err_base = err_cnt;
        send_bits(32'hDEAD_BEEF, 10, 1'b1);
        hold(1'b1, TMO + 60);
        chk("tmo_err", err_cnt - err_base, 1);
        chk("tmo_busy", {31'h0, busy}, 32'h0);
        chk("tmo_valid", {31'h0, valid}, 32'h1);
        chk("tmo_data", data, 32'h1234_5678);
        consume();

        // Glitch, then a clean frame.
        err_base = err_cnt;
        hold(1'b0, 10);
        hold(1'b1, 50);
        chk("glitch_err", err_cnt - err_base, 1);
        chk("glitch_busy", {31'h0, busy}, 32'h0);
        send_frame(32'hC35A_9601, 1'b0);
        chk("glitch_next", data, 32'hC35A_9601);
        chk("glitch_nvld", {31'h0, valid}, 32'h1);
        consume();

        // Line stuck low.
        err_base = err_cnt;
        hold(1'b0, 4 * Q + 30);
        hold(1'b1, 50);
        chk("stuck_err", err_cnt - err_base, 1);

        // ARM dropped mid-frame.
        err_base = err_cnt;
        send_bits(32'h5555_AAAA, 20, 1'b1);
        hold(1'b0, 20);
        arm = 1'b0;
        hold(1'b0, 5);
        chk("arm_busy", {31'h0, busy}, 32'h0);
        hold(1'b1, 20);
        arm = 1'b1;
        hold(1'b1, 20);
        chk("arm_err", err_cnt - err_base, 0);
        chk("arm_valid", {31'h0, valid}, 32'h0);

        // Reset mid-frame.
        err_base = err_cnt;
        send_bits(32'h0F0F_F0F0, 15, 1'b1);
        preset = 1'b1;
        hold(1'b1, 3);
        preset = 1'b0;
        hold(1'b1, 20);
        chk("prst_err", err_cnt - err_base, 0);
        chk("prst_valid", {31'h0, valid}, 32'h0);
        chk("prst_ovr", {31'h0, ovr}, 32'h0);
        chk("prst_busy", {31'h0, busy}, 32'h0);

        // Random frames with random consumption against a word-level model.
        mdata = 32'h0;
        mvalid = 1'b0;
        movr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                consume();
                mvalid = 1'b0;
            end
            w = $urandom;
            send_frame(w, 1'b1);
            if (!mvalid) begin
                mdata = w;
                mvalid = 1'b1;
            end else begin
                movr = 1'b1;
            end
            chk("rnd_data", data, mdata);
            chk("rnd_valid", {31'h0, valid}, {31'h0, mvalid});
            chk("rnd_ovr", {31'h0, ovr}, {31'h0, movr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
